wfifo_wr_ctrl: RTL and testbench
================================

// Module: wfifo_wr_ctrl
// PURPOSE
//  Write-side front end of the async FIFO, directly upstream of the write-pointer/full block.
//  Accepts a valid/ready stream and buffers it in a 2-entry skid buffer.
//  Issues wen/wdata to the pointer block and memory only when wfull is low.
//  Also computes the write-domain fill level and an almost-full flag from the synchronized gray read pointer.
// PARAMETERS
//  ASIZE         4   FIFO address width; depth = 2**ASIZE; pointers are ASIZE+1 bits
//  DSIZE         8   data width
//  AFULL_THRESH  12  wlevel >= AFULL_THRESH asserts walmost_full (1..2**ASIZE)
// PORTS
//  wclk          in   1        write-domain clock
//  wrst          in   1        synchronous active-high reset
//  s_valid       in   1        upstream data valid
//  s_data        in   DSIZE    upstream data
//  s_ready       out  1        upstream ready (registered)
//  wfull         in   1        registered full flag from the write-pointer block
//  w_rptr        in   ASIZE+1  read pointer, gray coded, already synchronized into wclk
//  wen           out  1        write strobe to the pointer block and memory (combinational)
//  wdata         out  DSIZE    write data to memory; valid when wen=1
//  wlevel        out  ASIZE+1  registered occupancy estimate, 0..2**ASIZE
//  walmost_full  out  1        registered, wlevel >= AFULL_THRESH
//  proto_err     out  1        sticky: upstream dropped s_valid before acceptance
// BEHAVIOUR
//  Reset
//   - wrst=1 clears the skid buffer to EMPTY, wcnt, wlevel, walmost_full and proto_err.
//   - While wrst=1: s_ready=0 and wen=0. s_ready=1 in the first cycle after wrst falls.
//   - Mid-operation reset discards buffered data.
//   - wrst must be asserted together with the write-pointer block reset; that block must not be reset alone.
//  Skid buffer FSM: EMPTY / ONE / TWO, FIFO ordered, head = oldest entry.
//   - push = s_valid & s_ready
//   - pop  = wen = (state != EMPTY) & ~wfull
//   - EMPTY: push -> ONE
//   - ONE:   push & ~pop -> TWO; pop & ~push -> EMPTY; push & pop or neither -> stay ONE
//   - TWO:   pop -> ONE; otherwise stay TWO. Push is impossible in TWO because s_ready=0.
//   - s_ready registered = next_state != TWO.
//   - wdata = head entry. Latency from s_valid to wen is at least 1 cycle; there is no bypass.
//   - Simultaneous push & pop in ONE: head is written out and the new entry becomes head the next cycle.
//  Full boundary
//   - wen never asserts while wfull=1.
//   - Data is held and s_ready drops once both entries are occupied.
//   - No data is lost or duplicated across any wfull toggle.
//  Level
//   - wcnt (ASIZE+1 bits) increments on each wen and wraps modulo 2**(ASIZE+1).
//   - rbin = gray-to-binary(w_rptr): rbin[ASIZE]=g[ASIZE]; rbin[i]=rbin[i+1]^g[i].
//   - wlevel <= wcnt - rbin, modulo 2**(ASIZE+1). Registered, so it lags wcnt by 1 cycle.
//   - walmost_full is registered from the same next-level compare.
//   - Sync lag only overestimates the level; this is conservative.
//   - Wrap case: wcnt=0x01, rbin=0x1F (ASIZE=4) -> wlevel=2.
//  proto_err
//   - Set when s_valid was 1 and s_ready 0 in cycle N, and s_valid=0 in cycle N+1.
//   - Cleared only by wrst.
// TESTING
//  1 Reset: hold wrst 3 cycles -> s_ready=0, wen=0, wlevel=0, walmost_full=0.
//    Release -> s_ready=1 next cycle.
//  2 Streaming: wfull=0, w_rptr tracking written count, 10 back-to-back s_valid words 0x00..0x09.
//    -> wen 10 consecutive cycles starting 1 cycle later, in-order wdata, s_ready stays 1.
//  3 Backpressure: wfull=1 while streaming 0xA0,0xA1,0xA2.
//    -> wen=0, buffer holds 0xA0,0xA1, s_ready=0, 0xA2 held.
//    Release wfull -> 0xA0,0xA1,0xA2 written in order with no loss.
//  4 Level/wrap: write 16 words with w_rptr frozen at gray(0) -> wlevel=16, walmost_full=1.
//    Then w_rptr=gray(0x1F) with wcnt=0x01 -> wlevel=2, walmost_full=0.
//  5 proto_err: wfull=1 and buffer TWO, s_valid=1 then 0 the next cycle -> proto_err=1 and stays 1 until wrst.
//  6 Mid-operation reset with 2 entries buffered: wrst 1 cycle -> no wen afterwards; wcnt=0 and wlevel=0.

Source files
------------

// File: rtl/wfifo_wr_ctrl.sv
// Write-side front end of the async FIFO: 2-entry skid buffer feeding the pointer block,
// plus a conservative write-domain fill level and almost-full flag.
module wfifo_wr_ctrl #(
    parameter int ASIZE        = 4,
    parameter int DSIZE        = 8,
    parameter int AFULL_THRESH = 12
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             s_valid,
    input  logic [DSIZE-1:0] s_data,
    output logic             s_ready,
    input  logic             wfull,
    input  logic [ASIZE:0]   w_rptr,
    output logic             wen,
    output logic [DSIZE-1:0] wdata,
    output logic [ASIZE:0]   wlevel,
    output logic             walmost_full,
    output logic             proto_err
);

    localparam int PW = ASIZE + 1;
    localparam logic [PW-1:0] THRESH = PW'(AFULL_THRESH);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DSIZE-1:0] head_q, head_d;
    logic [DSIZE-1:0] tail_q, tail_d;
    logic             s_ready_q, s_ready_d;
    logic             stall_q, stall_d;
    logic             proto_err_q, proto_err_d;
    logic [PW-1:0]    wcnt_q, wcnt_d;
    logic [PW-1:0]    wlevel_q, wlevel_d;
    logic             afull_q, afull_d;

    logic             push;
    logic             pop;
    logic [PW-1:0]    rbin;
    logic [PW-1:0]    level_next;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Reset masks both handshakes so nothing is written or accepted in a reset cycle.
    assign pop  = (state_q != ST_EMPTY) & ~wfull & ~wrst;
    assign push = s_valid & s_ready_q & ~wrst;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_ONE;
                    head_d  = s_data;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d = s_data;
                end else if (push) begin
                    state_d = ST_TWO;
                    tail_d  = s_data;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d = ST_ONE;
                    head_d  = tail_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        s_ready_d = (state_d != ST_TWO);
    end

    // Level uses the pre-increment count, so wlevel trails wcnt by one cycle.
    always_comb begin
        rbin        = gray2bin(w_rptr);
        level_next  = wcnt_q - rbin;
        wcnt_d      = wcnt_q + PW'(pop);
        wlevel_d    = level_next;
        afull_d     = (level_next >= THRESH);
        stall_d     = s_valid & ~s_ready_q;
        proto_err_d = proto_err_q | (stall_q & ~s_valid);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q     <= ST_EMPTY;
            s_ready_q   <= 1'b0;
            stall_q     <= 1'b0;
            proto_err_q <= 1'b0;
            wcnt_q      <= '0;
            wlevel_q    <= '0;
            afull_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_ready_q   <= s_ready_d;
            stall_q     <= stall_d;
            proto_err_q <= proto_err_d;
            wcnt_q      <= wcnt_d;
            wlevel_q    <= wlevel_d;
            afull_q     <= afull_d;
        end
    end

    // Entry storage is qualified by state, so it carries no reset.
    always_ff @(posedge wclk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign s_ready      = s_ready_q;
    assign wen          = pop;
    assign wdata        = head_q;
    assign wlevel       = wlevel_q;
    assign walmost_full = afull_q;
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_wfifo_wr_ctrl.sv
// Bench for wfifo_wr_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wfifo_wr_ctrl;

    localparam int ASIZE  = 4;
    localparam int DSIZE  = 8;
    localparam int THRESH = 12;

    logic             wclk = 1'b0;
    logic             wrst = 1'b1;
    logic             s_valid = 1'b0;
    logic [DSIZE-1:0] s_data = '0;
    logic             wfull = 1'b0;
    logic [ASIZE:0]   rptr_bin = '0;
    logic [ASIZE:0]   w_rptr;
    logic             s_ready;
    logic             wen;
    logic [DSIZE-1:0] wdata;
    logic [ASIZE:0]   wlevel;
    logic             walmost_full;
    logic             proto_err;

    assign w_rptr = rptr_bin ^ (rptr_bin >> 1);

    wfifo_wr_ctrl #(.ASIZE(ASIZE), .DSIZE(DSIZE), .AFULL_THRESH(THRESH)) dut (
        .wclk(wclk), .wrst(wrst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .wfull(wfull), .w_rptr(w_rptr), .wen(wen), .wdata(wdata), .wlevel(wlevel),
        .walmost_full(walmost_full), .proto_err(proto_err)
    );

    always #5 wclk = ~wclk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (value of registered outputs after the next edge)
    logic [DSIZE-1:0] m_q[$];
    int               m_cnt = 0;
    int               m_level = 0;
    bit               m_afull = 0, m_perr = 0, m_ready = 0, m_stall = 0, m_valid = 0;
    logic [DSIZE-1:0] wr_log[$];
    int               wen_seen = 0;
    bit               track = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge wclk) begin : compare
        bit e_wen;
        bit e_push;
        if (m_valid) begin
            e_wen = !wrst && (m_q.size() > 0) && !wfull;
            chk("s_ready", 32'(s_ready), 32'(m_ready));
            chk("wen", 32'(wen), 32'(e_wen));
            if (e_wen) chk("wdata", 32'(wdata), 32'(m_q[0]));
            chk("wlevel", 32'(wlevel), 32'(m_level));
            chk("walmost_full", 32'(walmost_full), 32'(m_afull));
            chk("proto_err", 32'(proto_err), 32'(m_perr));
        end
        if (wen === 1'b1) begin
            wr_log.push_back(wdata);
            wen_seen++;
        end
        if (wrst) begin
            m_q.delete();
            m_cnt = 0; m_level = 0; m_afull = 0; m_perr = 0;
            m_ready = 0; m_stall = 0; m_valid = 1;
        end else if (m_valid) begin
            e_wen = (m_q.size() > 0) && !wfull;
            if (m_stall && !s_valid) m_perr = 1;
            m_level = (m_cnt - int'(rptr_bin) + 32) % 32;
            m_afull = (m_level >= THRESH);
            e_push  = s_valid && m_ready;
            m_stall = s_valid && !m_ready;
            if (e_wen) begin
                void'(m_q.pop_front());
                m_cnt = (m_cnt + 1) % 32;
            end
            if (e_push) m_q.push_back(s_data);
            m_ready = (m_q.size() < 2);
        end
    end

    task automatic cyc();
        @(posedge wclk);
        #1;
        if (track) rptr_bin = 5'(m_cnt);
    endtask

    task automatic send(input logic [DSIZE-1:0] d);
        bit a;
        int n;
        s_valid = 1'b1;
        s_data  = d;
        n = 0;
        do begin
            a = s_ready;
            cyc();
            n++;
        end while (!a && n < 50);
        if (!a) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: word %0h not accepted within %0d cycles", d, n);
        end
    endtask

    initial begin : main
        int base;
        bit a;
        bit hold;

        // Reset
        wrst = 1'b1;
        repeat (3) cyc();
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_wlevel", 32'(wlevel), 32'd0);
        chk("rst_afull", 32'(walmost_full), 32'd0);
        wrst = 1'b0;
        cyc();
        chk("ready_after_rst", 32'(s_ready), 32'd1);

        // Streaming
        base = wr_log.size();
        for (int i = 0; i < 10; i++) send(8'(i));
        s_valid = 1'b0;
        repeat (4) cyc();
        chk("stream_count", 32'(wr_log.size() - base), 32'd10);
        for (int i = 0; i < 10; i++) chk("stream_order", 32'(wr_log[base+i]), 32'(i));

        // Backpressure
        wfull = 1'b1;
        send(8'hA0);
        send(8'hA1);
        s_valid = 1'b1;
        s_data  = 8'hA2;
        repeat (3) cyc();
        chk("bp_s_ready", 32'(s_ready), 32'd0);
        chk("bp_wen", 32'(wen), 32'd0);
        chk("bp_head", 32'(wdata), 32'hA0);
        base = wr_log.size();
        wfull = 1'b0;
        #1;
        chk("bp_release_wen", 32'(wen), 32'd1);
        send(8'hA2);
        s_valid = 1'b0;
        repeat (4) cyc();
        chk("bp_count", 32'(wr_log.size() - base), 32'd3);
        chk("bp_w0", 32'(wr_log[base]), 32'hA0);
        chk("bp_w1", 32'(wr_log[base+1]), 32'hA1);
        chk("bp_w2", 32'(wr_log[base+2]), 32'hA2);

        // Level and wrap
        track = 0;
        rptr_bin = '0;
        wrst = 1'b1;
        repeat (2) cyc();
        wrst = 1'b0;
        cyc();
        for (int i = 0; i < 16; i++) send(8'(8'h20 + i));
        s_valid = 1'b0;
        repeat (3) cyc();
        chk("level16", 32'(wlevel), 32'd16);
        chk("afull16", 32'(walmost_full), 32'd1);
        track = 1;
        for (int i = 0; i < 17; i++) send(8'(8'h40 + i));
        s_valid = 1'b0;
        repeat (4) cyc();
        track = 0;
        rptr_bin = 5'h1F;
        repeat (2) cyc();
        chk("wrap_level", 32'(wlevel), 32'd2);
        chk("wrap_afull", 32'(walmost_full), 32'd0);

        // Protocol error
        track = 1;
        wfull = 1'b1;
        send(8'h01);
        send(8'h02);
        s_valid = 1'b1;
        s_data  = 8'h03;
        cyc();
        s_valid = 1'b0;
        repeat (2) cyc();
        chk("perr_set", 32'(proto_err), 32'd1);
        wfull = 1'b0;
        repeat (5) cyc();
        chk("perr_sticky", 32'(proto_err), 32'd1);

        // Randomized traffic
        track = 0;
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            wfull = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 9) == 0) rptr_bin = 5'($urandom);
            else rptr_bin = 5'(m_cnt - int'($urandom_range(0, 3)));
            wrst = ($urandom_range(0, 199) == 0);
            if (!hold) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = 8'($urandom);
            end
            a = s_ready;
            cyc();
            hold = s_valid && !a && !wrst;
        end

        // Mid-operation reset with two entries buffered
        s_valid = 1'b0;
        wfull = 1'b1;
        wrst = 1'b1;
        cyc();
        wrst = 1'b0;
        track = 1;
        cyc();
        send(8'h55);
        send(8'h66);
        s_valid = 1'b0;
        cyc();
        chk("mid_two_ready", 32'(s_ready), 32'd0);
        base = wen_seen;
        wfull = 1'b0;
        wrst = 1'b1;
        cyc();
        wrst = 1'b0;
        track = 0;
        rptr_bin = '0;
        repeat (5) cyc();
        chk("mid_no_wen", 32'(wen_seen - base), 32'd0);
        chk("mid_wlevel", 32'(wlevel), 32'd0);
        chk("mid_perr", 32'(proto_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
